i2c_write_master: RTL and testbench

//  Single-master I2C write engine: after reset it repeatedly sends a one-byte write frame.

---
 rtl/i2c_pkg.sv | 45 ++++
 rtl/i2c_write_master_qtr_tick.sv | 26 ++
 rtl/i2c_write_master.sv | 124 ++++++++++++
 tb/tb_i2c_write_master.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write master: FSM states, R/W constant,
// default timing and the per-quarter bus drive table.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK1,
        DATA,
        ACK2,
        STOP,
        GAP
    } i2c_state_t;

    localparam logic I2C_WRITE       = 1'b0;
    localparam int   DEF_CLK_PER_QTR = 25;
    localparam int   DEF_BUS_FREE    = 4;

    typedef struct packed {
        logic scl;
        logic oe;   // 1 = pull SDA low
    } bus_t;

    // SCL level and SDA pull-down for a given state and quarter q0..q3.
    function automatic bus_t bus_drive(i2c_state_t st, logic [1:0] q, logic bit_val);
        bus_t b;
        b = '{scl: 1'b1, oe: 1'b0};
        case (st)
            START:      b.oe = q[1];
            ADDR, DATA: begin
                b.scl = q[1];
                b.oe  = ~bit_val;
            end
            ACK1, ACK2: b.scl = q[1];
            STOP:       begin
                b.scl = (q != 2'd0);
                b.oe  = (q != 2'd3);
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_write_master_qtr_tick.sv
// Quarter-bit tick divider: counts 0..CLK_PER_QTR-1 and pulses tick on the
// last count, so one quarter of an SCL bit is CLK_PER_QTR clk cycles.
module i2c_qtr_tick #(
    parameter int CLK_PER_QTR = 25
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (CLK_PER_QTR > 1) ? $clog2(CLK_PER_QTR) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_PER_QTR - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/i2c_write_master.sv
// Single-master I2C write engine: endlessly sends START, {addr,W}, ACK,
// data, ACK, STOP, then BUS_FREE idle bit-times.
//
// state | meaning
// IDLE  | one released bit-time after reset
// START | SDA falls at q2 with SCL high; addr/data latched on entry
// ADDR  | 7-bit address + W, MSB first
// ACK1  | address ACK sampled at q3 entry; NACK skips to STOP
// DATA  | latched payload, MSB first
// ACK2  | data ACK sampled, result ignored
// STOP  | SDA rises at q3 with SCL high
// GAP   | BUS_FREE released bit-times before the next START
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_PER_QTR = DEF_CLK_PER_QTR,
    parameter int BUS_FREE    = DEF_BUS_FREE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    inout  wire        i2c_sda,
    output logic       i2c_scl
);

    localparam int GW = $clog2(BUS_FREE + 1);

    logic            tick;
    i2c_state_t      state;
    logic [1:0]      qtr;
    logic [2:0]      bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      shift;
    logic [7:0]      data_q;
    logic            nack;
    bus_t            bus;

    i2c_qtr_tick #(.CLK_PER_QTR(CLK_PER_QTR)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign i2c_scl = bus.scl;
    assign i2c_sda = bus.oe ? 1'b0 : 1'bz;

    // Bus outputs are registered for the quarter being entered, so every
    // branch drives the table entry of the next (state, quarter) pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            qtr     <= 2'd0;
            bit_cnt <= 3'd0;
            gap_cnt <= '0;
            shift   <= 8'h00;
            data_q  <= 8'h00;
            nack    <= 1'b0;
            bus     <= '{scl: 1'b1, oe: 1'b0};
        end else if (tick) begin
            qtr <= qtr + 2'd1;
            if (qtr != 2'd3) begin
                bus <= bus_drive(state, qtr + 2'd1, shift[7]);
                if (qtr == 2'd2 && (state == ACK1 || state == ACK2))
                    nack <= i2c_sda;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= START;
                        shift  <= {addr, I2C_WRITE};
                        data_q <= data;
                        bus    <= bus_drive(START, 2'd0, 1'b0);
                    end
                    GAP: begin
                        if (gap_cnt == GW'(BUS_FREE - 1)) begin
                            state   <= START;
                            gap_cnt <= '0;
                            shift   <= {addr, I2C_WRITE};
                            data_q  <= data;
                            bus     <= bus_drive(START, 2'd0, 1'b0);
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    START: begin
                        state   <= ADDR;
                        bit_cnt <= 3'd0;
                        bus     <= bus_drive(ADDR, 2'd0, shift[7]);
                    end
                    ADDR, DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= (state == ADDR) ? ACK1 : ACK2;
                            bus   <= bus_drive(ACK1, 2'd0, 1'b0);
                        end else begin
                            shift <= {shift[6:0], 1'b0};
                            bus   <= bus_drive(state, 2'd0, shift[6]);
                        end
                    end
                    ACK1: begin
                        if (!nack) begin
                            state <= DATA;
                            shift <= data_q;
                            bus   <= bus_drive(DATA, 2'd0, data_q[7]);
                        end else begin
                            state <= STOP;
                            bus   <= bus_drive(STOP, 2'd0, 1'b0);
                        end
                    end
                    ACK2: begin
                        state <= STOP;
                        bus   <= bus_drive(STOP, 2'd0, 1'b0);
                    end
                    STOP: begin
                        state   <= GAP;
                        gap_cnt <= '0;
                        bus     <= bus_drive(GAP, 2'd0, 1'b0);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master with a bus monitor and a simple
// ACKing peripheral on a pulled-up SDA line.
module tb_i2c_write_master;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] addr  = 7'h2A;
    logic [7:0] data  = 8'hAA;
    wire        sda;
    wire        scl;

    logic       slave_en = 1'b1;
    logic       slave_oe = 1'b0;

    pullup (sda);
    assign sda = slave_oe ? 1'b0 : 1'bz;

    i2c_write_master dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .data    (data),
        .i2c_sda (sda),
        .i2c_scl (scl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    int          start_cnt = 0;
    int          stop_cnt  = 0;
    int          hi_edges  = 0;
    int          last_start = 0;
    int          last_stop  = 0;
    int          r1 = 0;
    int          r2 = 0;
    int          nbits = 0;
    logic [31:0] fbits  = 32'h0;
    logic [31:0] f_last = 32'h0;
    int          f_n = 0;
    logic        acked = 1'b0;
    logic [6:0]  s_addr = 7'h0;
    logic [7:0]  s_data = 8'h0;

    // Bus monitor plus peripheral: frames are the SDA values at SCL rises
    // from START to STOP; the peripheral pulls SDA low after the 8th/17th fall.
    always @(negedge clk) begin
        prev_scl <= scl;
        prev_sda <= sda;
        if (prev_scl && scl && (prev_sda != sda))
            hi_edges <= hi_edges + 1;
        if (prev_scl && scl && prev_sda && !sda) begin
            start_cnt  <= start_cnt + 1;
            last_start <= cyc;
            nbits      <= 0;
            fbits      <= 32'h0;
            slave_oe   <= 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            stop_cnt  <= stop_cnt + 1;
            last_stop <= cyc;
            f_last    <= fbits;
            f_n       <= nbits;
        end else if (!prev_scl && scl) begin
            fbits <= {fbits[30:0], sda};
            nbits <= nbits + 1;
            if (nbits == 0) r1 <= cyc;
            if (nbits == 1) r2 <= cyc;
        end else if (prev_scl && !scl) begin
            if (nbits == 8) begin
                s_addr   <= fbits[7:1];
                acked    <= slave_en;
                slave_oe <= slave_en;
            end else if (nbits == 17) begin
                s_data   <= fbits[7:0];
                slave_oe <= acked;
            end else begin
                slave_oe <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // which: 0 = START count, 1 = STOP count
    task automatic wait_for(input string tag, input int which, input int n, input int budget);
        int k;
        int cur;
        k   = 0;
        cur = (which == 0) ? start_cnt : stop_cnt;
        while (cur < n && k < budget) begin
            @(negedge clk);
            k++;
            cur = (which == 0) ? start_cnt : stop_cnt;
        end
        check(tag, 32'(cur >= n), 32'd1);
    endtask

    localparam logic [31:0] FR_54_AA = {13'd0, 8'h54, 1'b0, 8'hAA, 1'b0, 1'b0};
    localparam logic [31:0] FR_NACK  = {22'd0, 8'h54, 1'b1, 1'b0};
    localparam logic [31:0] FR_22_3C = {13'd0, 8'h22, 1'b0, 8'h3C, 1'b0, 1'b0};

    int rel;
    int s1;
    int s5;

    initial begin
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);

        // T1: ACKing peripheral, addr 2A / data AA
        reset = 1'b1;
        rel   = cyc;
        repeat (90) @(negedge clk);
        check("idle_scl", 32'(scl), 32'd1);
        check("idle_sda", 32'(sda), 32'd1);
        check("idle_no_start", 32'(start_cnt), 32'd0);
        wait_for("t1_start_seen", 0, 1, 500);
        check("t1_rel_to_start", 32'(last_start - rel), 32'd150);
        wait_for("t1_stop_seen", 1, 1, 5000);
        check("t1_frame", f_last, FR_54_AA);
        check("t1_nbits", 32'(f_n), 32'd19);
        check("t1_slave_addr", 32'(s_addr), 32'h2A);
        check("t1_slave_data", 32'(s_data), 32'hAA);
        // SDA falls at START q2 and rises at STOP q3: 2000 - 50 - 25 clk apart
        check("t1_start_to_stop", 32'(last_stop - last_start), 32'd1925);
        check("t1_scl_period", 32'(r2 - r1), 32'd100);
        s1 = last_start;

        // T2: no peripheral -> NACK, immediate STOP
        slave_en = 1'b0;
        wait_for("t2_stop_seen", 1, 2, 5000);
        check("t2_frame", f_last, FR_NACK);
        check("t2_nbits", 32'(f_n), 32'd10);
        check("t2_start_to_start", 32'(last_start - s1), 32'd2400);
        check("t2_start_to_stop", 32'(last_stop - last_start), 32'd1025);

        // T4: addr/data change during ADDR of frame 3
        slave_en = 1'b1;
        wait_for("t4_start3_seen", 0, 3, 5000);
        repeat (300) @(negedge clk);
        addr = 7'h11;
        data = 8'h3C;
        wait_for("t4_stop3_seen", 1, 3, 5000);
        check("t4_frame3", f_last, FR_54_AA);
        wait_for("t4_stop4_seen", 1, 4, 5000);
        check("t4_frame4", f_last, FR_22_3C);
        check("t4_slave_addr", 32'(s_addr), 32'h11);
        check("t4_slave_data", 32'(s_data), 32'h3C);

        // T3: reset during DATA bit 2, SCL low half
        wait_for("t3_start5_seen", 0, 5, 5000);
        s5 = last_start;
        while (cyc < s5 + 1160) @(negedge clk);
        check("t3_pre_scl", 32'(scl), 32'd0);
        reset = 1'b0;
        #1;
        check("t3_async_scl", 32'(scl), 32'd1);
        check("t3_async_sda", 32'(sda), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        rel   = cyc;
        repeat (90) @(negedge clk);
        check("t3_idle_scl", 32'(scl), 32'd1);
        check("t3_idle_sda", 32'(sda), 32'd1);
        check("t3_idle_no_start", 32'(start_cnt), 32'd5);
        wait_for("t3_start6_seen", 0, 6, 500);
        check("t3_rel_to_start", 32'(last_start - rel), 32'd150);
        wait_for("t3_stop6_seen", 1, 5, 5000);
        check("t3_frame6", f_last, FR_22_3C);

        // Only START/STOP conditions may move SDA while SCL is high
        check("total_starts", 32'(start_cnt), 32'd6);
        check("total_stops", 32'(stop_cnt), 32'd5);
        check("sda_edges_scl_high", 32'(hi_edges), 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
